// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared definitions for the Viterbi traceback engine.
//   K_MAX       maximum constraint length
//   N_ST        number of trellis states = decision word width
//   state_t     trellis state register type (K_MAX-1 bits)
//   tb_fsm_e    traceback FSM encoding
//   mask_k      keeps the low k-1 state bits for a runtime constraint length k
//   wrap_dec    survivor address decrement with wrap to depth-1
//   tb_next_st  one traceback move: new state from current state and decision bit
package viterbi_pkg;

  localparam int unsigned K_MAX      = 7;
  localparam int unsigned N_ST       = 2 ** (K_MAX - 1);
  localparam int unsigned W_ADDR_MAX = 16;

  typedef logic [K_MAX-2:0] state_t;

  typedef enum logic [2:0] {
    TB_IDLE = 3'd0,
    TB_RD   = 3'd1,
    TB_WAIT = 3'd2,
    TB_STEP = 3'd3,
    TB_EMIT = 3'd4,
    TB_DONE = 3'd5
  } tb_fsm_e;

  // Mask keeping the k-1 meaningful state bits.
  function automatic state_t mask_k(input logic [2:0] k);
    state_t m;
    m = '0;
    for (int i = 0; i < int'(K_MAX) - 1; i++) begin
      if (i < int'(k) - 1) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Address minus one; 0 wraps to depth-1 so non power-of-two depths work.
  function automatic logic [W_ADDR_MAX-1:0] wrap_dec(input logic [W_ADDR_MAX-1:0] addr,
                                                     input logic [W_ADDR_MAX-1:0] depth);
    logic [W_ADDR_MAX-1:0] r;
    if (addr == '0) begin
      r = depth - 16'd1;
    end else begin
      r = addr - 16'd1;
    end
    return r;
  endfunction

  // Traceback move: shift state right by one and insert the decision bit
  // at position k-2; bits above the active state width stay 0.
  function automatic state_t tb_next_st(input state_t st, input logic d, input logic [2:0] k);
    state_t sh;
    state_t ns;
    sh = st >> 1;
    ns = '0;
    for (int i = 0; i < int'(K_MAX) - 1; i++) begin
      if (i == int'(k) - 2) begin
        ns[i] = d;
      end else if (i < int'(k) - 2) begin
        ns[i] = sh[i];
      end else begin
        ns[i] = 1'b0;
      end
    end
    return ns;
  endfunction

endpackage

// File: rtl/viterbi_tb_packer.sv
// viterbi_tb_packer: collects decoded bits into W_OUT-bit words and presents
// them on a valid/ready stream.
//   push_i/bit_i    append one bit (first pushed lands in bit 0 of the pack)
//   load_i/last_i   move the pack (including a bit pushed in the same cycle)
//                   to the output registers and clear the pack
//   cnt_o           bits currently held in the pack
//   out_*           output word, bit count, last flag, valid; out_ready_i accepts
// Build option: VITERBI_TB_BITREV_EN reverses each word across its valid bits.
module viterbi_tb_packer
  import viterbi_pkg::*;
#(
  parameter int unsigned W_OUT = 32,
  localparam int unsigned W_NB = $clog2(W_OUT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic             rst_sync_i,
  input  logic             push_i,
  input  logic             bit_i,
  input  logic             load_i,
  input  logic             last_i,
  input  logic             out_ready_i,
  output logic [W_NB-1:0]  cnt_o,
  output logic [W_OUT-1:0] out_data_o,
  output logic [W_NB-1:0]  out_nbits_o,
  output logic             out_last_o,
  output logic             out_valid_o
);

  logic [W_OUT-1:0] pack_r;
  logic [W_NB-1:0]  cnt_r;
  logic [W_OUT-1:0] data_r;
  logic [W_NB-1:0]  nbits_r;
  logic             last_r;
  logic             valid_r;

  logic [W_OUT-1:0] pack_push_s;
  logic [W_NB-1:0]  cnt_push_s;
  logic [W_OUT-1:0] word_s;
`ifdef VITERBI_TB_BITREV_EN
  logic [W_OUT-1:0] rev_s;
`endif

  // Pack contents after an optional push, and the word it would become.
  always_comb begin
    pack_push_s = pack_r;
    cnt_push_s  = cnt_r;
    for (int i = 0; i < int'(W_OUT); i++) begin
      if (push_i && (cnt_r == W_NB'(i))) begin
        pack_push_s[i] = bit_i;
      end else begin
        pack_push_s[i] = pack_r[i];
      end
    end
    if (push_i) begin
      cnt_push_s = cnt_r + W_NB'(1);
    end else begin
      cnt_push_s = cnt_r;
    end
`ifdef VITERBI_TB_BITREV_EN
    // Full-width reverse, then drop the empty low end so the reversal is
    // across the valid bits only; upper unused bits come out 0.
    rev_s = '0;
    for (int i = 0; i < int'(W_OUT); i++) begin
      rev_s[i] = pack_push_s[W_OUT-1-i];
    end
    word_s = rev_s >> (W_NB'(W_OUT) - cnt_push_s);
`else
    word_s = pack_push_s;
`endif
  end

  // Pack accumulation and output word registers with valid/ready hold.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      pack_r  <= '0;
      cnt_r   <= '0;
      data_r  <= '0;
      nbits_r <= '0;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (rst_sync_i) begin
      pack_r  <= '0;
      cnt_r   <= '0;
      data_r  <= '0;
      nbits_r <= '0;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (load_i) begin
      data_r  <= word_s;
      nbits_r <= cnt_push_s;
      last_r  <= last_i;
      valid_r <= 1'b1;
      pack_r  <= '0;
      cnt_r   <= '0;
    end else begin
      pack_r <= pack_push_s;
      cnt_r  <= cnt_push_s;
      if (valid_r && out_ready_i) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign cnt_o       = cnt_r;
  assign out_data_o  = data_r;
  assign out_nbits_o = nbits_r;
  assign out_last_o  = last_r;
  assign out_valid_o = valid_r;

endmodule

// File: rtl/viterbi_tb_engine.sv
// viterbi_tb_engine: parametrised Viterbi traceback engine.
// Walks the survivor memory backwards from start_addr_i / start_state_i,
// recovering one bit per step; the first tb_len_i - out_len_i steps are merge
// steps and are discarded, the last out_len_i bits are packed into W_OUT-bit
// words on a valid/ready stream.
// Ports:
//   clk_i, rst_an_i (async active-low), rst_sync_i (sync clear)
//   start_i, k_i, start_state_i, start_addr_i, tb_len_i, out_len_i : job config
//   busy_o                     : traceback in progress
//   mem_rd_o, mem_addr_o       : survivor read request
//   mem_rdata_i                : decision word, RD_LAT cycles after mem_rd_o
//   out_data_o, out_nbits_o, out_last_o, out_valid_o, out_ready_i : output stream
// K_MAX / N_ST come from viterbi_pkg.
// Build option: VITERBI_TB_BITREV_EN makes bit 0 of each word the oldest bit
// (handled in viterbi_tb_packer); otherwise bit 0 is the first bit recovered.
module viterbi_tb_engine
  import viterbi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned W_ADDR    = 6,
  parameter int unsigned W_LEN     = 8,
  parameter int unsigned W_OUT     = 32,
  parameter int unsigned RD_LAT    = 1,
  localparam int unsigned W_NB     = $clog2(W_OUT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_an_i,
  input  logic              rst_sync_i,
  input  logic              start_i,
  input  logic [2:0]        k_i,
  input  logic [K_MAX-2:0]  start_state_i,
  input  logic [W_ADDR-1:0] start_addr_i,
  input  logic [W_LEN-1:0]  tb_len_i,
  input  logic [W_LEN-1:0]  out_len_i,
  output logic              busy_o,
  output logic              mem_rd_o,
  output logic [W_ADDR-1:0] mem_addr_o,
  input  logic [N_ST-1:0]   mem_rdata_i,
  output logic [W_OUT-1:0]  out_data_o,
  output logic [W_NB-1:0]   out_nbits_o,
  output logic              out_last_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  localparam logic [1:0]      WAIT_LAST = 2'(RD_LAT - 1);
  localparam logic [W_NB-1:0] PACK_FULL = W_NB'(W_OUT);

  tb_fsm_e           state_r;
  logic [2:0]        k_r;
  state_t            st_r;
  logic [W_ADDR-1:0] addr_r;
  logic [W_LEN-1:0]  step_cnt_r;
  logic [W_LEN-1:0]  out_len_r;
  logic [1:0]        wait_cnt_r;
  logic              d_r;
  logic              busy_r;
  logic              mem_rd_r;

  tb_fsm_e           next_state_s;
  logic              keep_s;
  logic              push_s;
  logic              load_s;
  logic              last_s;
  logic [W_LEN-1:0]  step_dec_s;
  logic [W_NB-1:0]   pack_cnt_s;
  logic [W_NB-1:0]   cnt_after_s;

  // Next-state decode and packer control.
  always_comb begin
    next_state_s = state_r;
    push_s       = 1'b0;
    load_s       = 1'b0;
    last_s       = 1'b0;
    keep_s       = (step_cnt_r <= out_len_r);
    step_dec_s   = step_cnt_r - W_LEN'(1);
    cnt_after_s  = pack_cnt_s + {{(W_NB-1){1'b0}}, keep_s};
    case (state_r)
      TB_IDLE, TB_DONE: begin
        if (start_i) begin
          next_state_s = TB_RD;
        end else begin
          next_state_s = TB_IDLE;
        end
      end
      TB_RD: begin
        next_state_s = TB_WAIT;
      end
      TB_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          next_state_s = TB_STEP;
        end else begin
          next_state_s = TB_WAIT;
        end
      end
      TB_STEP: begin
        push_s = keep_s;
        // The step's own bit is pushed and loaded in the same edge, so the
        // word is valid on the first EMIT cycle.
        if ((cnt_after_s == PACK_FULL) ||
            ((step_dec_s == '0) && (cnt_after_s != '0))) begin
          load_s       = 1'b1;
          last_s       = (step_dec_s == '0);
          next_state_s = TB_EMIT;
        end else if (step_dec_s == '0) begin
          next_state_s = TB_IDLE;
        end else begin
          next_state_s = TB_RD;
        end
      end
      TB_EMIT: begin
        if (out_valid_o && out_ready_i) begin
          if (step_cnt_r == '0) begin
            next_state_s = TB_DONE;
          end else begin
            next_state_s = TB_RD;
          end
        end else begin
          next_state_s = TB_EMIT;
        end
      end
      default: begin
        next_state_s = TB_IDLE;
      end
    endcase
  end

  // State register, job configuration and traceback datapath.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_r    <= TB_IDLE;
      k_r        <= 3'd0;
      st_r       <= '0;
      addr_r     <= '0;
      step_cnt_r <= '0;
      out_len_r  <= '0;
      wait_cnt_r <= 2'd0;
      d_r        <= 1'b0;
      busy_r     <= 1'b0;
      mem_rd_r   <= 1'b0;
    end else if (rst_sync_i) begin
      state_r    <= TB_IDLE;
      k_r        <= 3'd0;
      st_r       <= '0;
      addr_r     <= '0;
      step_cnt_r <= '0;
      out_len_r  <= '0;
      wait_cnt_r <= 2'd0;
      d_r        <= 1'b0;
      busy_r     <= 1'b0;
      mem_rd_r   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      busy_r   <= (next_state_s == TB_RD)   || (next_state_s == TB_WAIT) ||
                  (next_state_s == TB_STEP) || (next_state_s == TB_EMIT);
      mem_rd_r <= (next_state_s == TB_RD);
      case (state_r)
        TB_IDLE, TB_DONE: begin
          if (start_i) begin
            k_r        <= k_i;
            st_r       <= start_state_i & mask_k(k_i);
            addr_r     <= start_addr_i;
            step_cnt_r <= tb_len_i;
            out_len_r  <= out_len_i;
          end
        end
        TB_RD: begin
          wait_cnt_r <= 2'd0;
          addr_r     <= W_ADDR'(wrap_dec(W_ADDR_MAX'(addr_r), W_ADDR_MAX'(MEM_DEPTH)));
        end
        TB_WAIT: begin
          // Captured every wait cycle; the value from the last one is the
          // decision word for the outstanding read.
          wait_cnt_r <= wait_cnt_r + 2'd1;
          d_r        <= mem_rdata_i[st_r];
        end
        TB_STEP: begin
          st_r       <= tb_next_st(st_r, d_r, k_r);
          step_cnt_r <= step_dec_s;
        end
        default: begin
        end
      endcase
    end
  end

  viterbi_tb_packer #(
    .W_OUT(W_OUT)
  ) u_packer (
    .clk_i      (clk_i),
    .rst_an_i   (rst_an_i),
    .rst_sync_i (rst_sync_i),
    .push_i     (push_s),
    .bit_i      (st_r[0]),
    .load_i     (load_s),
    .last_i     (last_s),
    .out_ready_i(out_ready_i),
    .cnt_o      (pack_cnt_s),
    .out_data_o (out_data_o),
    .out_nbits_o(out_nbits_o),
    .out_last_o (out_last_o),
    .out_valid_o(out_valid_o)
  );

  assign busy_o     = busy_r;
  assign mem_rd_o   = mem_rd_r;
  assign mem_addr_o = addr_r;

endmodule

// File: tb/tb_viterbi_tb_engine.sv
// Directed testbench for viterbi_tb_engine with a 1-cycle-latency survivor
// memory model and capture queues for reads and output words.
module tb_viterbi_tb_engine;
  import viterbi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_sync;
  logic        start;
  logic [2:0]  k;
  logic [5:0]  start_state;
  logic [5:0]  start_addr;
  logic [7:0]  tb_len;
  logic [7:0]  out_len;
  logic        busy;
  logic        mem_rd;
  logic [5:0]  mem_addr;
  logic [63:0] rdata = 64'd0;
  logic [31:0] out_data;
  logic [5:0]  out_nbits;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  logic [63:0] mem [64];
  logic [5:0]  rd_q [$];
  logic [31:0] wd_q [$];
  logic [5:0]  wn_q [$];
  logic        wl_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  viterbi_tb_engine dut (
    .clk_i        (clk),
    .rst_an_i     (rst_n),
    .rst_sync_i   (rst_sync),
    .start_i      (start),
    .k_i          (k),
    .start_state_i(start_state),
    .start_addr_i (start_addr),
    .tb_len_i     (tb_len),
    .out_len_i    (out_len),
    .busy_o       (busy),
    .mem_rd_o     (mem_rd),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (rdata),
    .out_data_o   (out_data),
    .out_nbits_o  (out_nbits),
    .out_last_o   (out_last),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready)
  );

  // Survivor memory model, read latency 1.
  always @(posedge clk) begin
    if (mem_rd) rdata <= mem[mem_addr];
  end

  // Record read addresses and accepted output words.
  always @(posedge clk) begin
    if (mem_rd) rd_q.push_back(mem_addr);
    if (out_valid && out_ready) begin
      wd_q.push_back(out_data);
      wn_q.push_back(out_nbits);
      wl_q.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [63:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic clear_q();
    rd_q.delete();
    wd_q.delete();
    wn_q.delete();
    wl_q.delete();
  endtask

  task automatic run(input logic [2:0] kk, input logic [5:0] ss, input logic [5:0] aa,
                     input logic [7:0] tl, input logic [7:0] ol);
    @(negedge clk);
    k = kk; start_state = ss; start_addr = aa; tb_len = tl; out_len = ol;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < 3000) ? 64'd1 : 64'd0, 64'd1);
  endtask

  logic [5:0] exp_wrap [4] = '{6'd1, 6'd0, 6'd63, 6'd62};
  logic [31:0] exp_pat;

  initial begin
    rst_n = 1'b0; rst_sync = 1'b0; start = 1'b0; k = 3'd0; start_state = 6'd0;
    start_addr = 6'd0; tb_len = 8'd0; out_len = 8'd0; out_ready = 1'b1;
    fill(64'd0);
    #22 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_nbits", out_nbits, 0);
    check("rst_last", out_last, 0);

    // 1: K=7, zero decisions, addr 10, tb=8 out=8
    clear_q();
    run(3'd7, 6'd0, 6'd10, 8'd8, 8'd8);
    check("t1_busy_rise", busy, 1);
    wait_idle("t1_timeout");
    check("t1_nreads", rd_q.size(), 8);
    if (rd_q.size() == 8) begin
      check("t1_addr_first", rd_q[0], 10);
      check("t1_addr_last", rd_q[7], 3);
    end
    check("t1_nwords", wd_q.size(), 1);
    if (wd_q.size() == 1) begin
      check("t1_data", wd_q[0], 0);
      check("t1_nbits", wn_q[0], 8);
      check("t1_last", wl_q[0], 1);
    end

    // 2: address wrap 1,0,63,62
    clear_q();
    run(3'd7, 6'd0, 6'd1, 8'd4, 8'd4);
    wait_idle("t2_timeout");
    check("t2_nreads", rd_q.size(), 4);
    if (rd_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t2_wrap_addr", rd_q[i], exp_wrap[i]);
    end

    // 3: k=3, all-ones decisions, start state masked to 2'b11
    clear_q();
    fill(64'hFFFF_FFFF_FFFF_FFFF);
    run(3'd3, 6'h3F, 6'd30, 8'd4, 8'd4);
    wait_idle("t3_timeout");
    check("t3_nwords", wd_q.size(), 1);
    if (wd_q.size() == 1) begin
      check("t3_data", wd_q[0], 32'hF);
      check("t3_nbits", wn_q[0], 4);
      check("t3_last", wl_q[0], 1);
    end

    // 7: K=7 state walk 5 -> 34 -> 17 -> 40, bits 1,0,1,0
    clear_q();
    fill(64'd0);
    mem[20] = 64'h20;
    mem[18] = 64'h2_0000;
`ifdef VITERBI_TB_BITREV_EN
    exp_pat = 32'hA;
`else
    exp_pat = 32'h5;
`endif
    run(3'd7, 6'd5, 6'd20, 8'd4, 8'd4);
    wait_idle("t7_timeout");
    check("t7_nreads", rd_q.size(), 4);
    if (rd_q.size() == 4) check("t7_addr_last", rd_q[3], 17);
    check("t7_nwords", wd_q.size(), 1);
    if (wd_q.size() == 1) begin
      check("t7_data", wd_q[0], exp_pat);
      check("t7_nbits", wn_q[0], 4);
    end

    // 4 + 5: tb=40 out=36, first word stalled for 10 cycles
    clear_q();
    fill(64'hFFFF_FFFF_FFFF_FFFF);
    out_ready = 1'b0;
    run(3'd7, 6'h3F, 6'd50, 8'd40, 8'd36);
    begin
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("t4_valid_timeout", (n < 1000) ? 64'd1 : 64'd0, 64'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_stall_valid", out_valid, 1);
      check("t5_stall_data", out_data, 32'hFFFF_FFFF);
      check("t5_stall_nbits", out_nbits, 32);
      check("t5_stall_last", out_last, 0);
      check("t5_stall_rd", mem_rd, 0);
    end
    out_ready = 1'b1;
    wait_idle("t4_timeout");
    check("t4_nreads", rd_q.size(), 40);
    check("t4_nwords", wd_q.size(), 2);
    if (wd_q.size() == 2) begin
      check("t4_w0_data", wd_q[0], 32'hFFFF_FFFF);
      check("t4_w0_nbits", wn_q[0], 32);
      check("t4_w0_last", wl_q[0], 0);
      check("t4_w1_data", wd_q[1], 32'hF);
      check("t4_w1_nbits", wn_q[1], 4);
      check("t4_w1_last", wl_q[1], 1);
    end

    // out_len == 0: all merge steps, no word
    clear_q();
    run(3'd7, 6'd0, 6'd5, 8'd3, 8'd0);
    wait_idle("t8_timeout");
    check("t8_nreads", rd_q.size(), 3);
    check("t8_nwords", wd_q.size(), 0);

    // 6: rst_sync mid-run, restart, start while busy ignored
    clear_q();
    run(3'd7, 6'h3F, 6'd40, 8'd20, 8'd20);
    repeat (7) @(negedge clk);
    rst_sync = 1'b1;
    @(negedge clk);
    rst_sync = 1'b0;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_valid", out_valid, 0);
    check("t6_abort_rd", mem_rd, 0);
    check("t6_abort_addr", mem_addr, 0);
    check("t6_abort_nwords", wd_q.size(), 0);
    clear_q();
    run(3'd3, 6'h3, 6'd5, 8'd4, 8'd4);
    @(negedge clk);
    k = 3'd7; start_state = 6'd0; start_addr = 6'd40; tb_len = 8'd8; out_len = 8'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t6_timeout");
    check("t6_nreads", rd_q.size(), 4);
    if (rd_q.size() == 4) check("t6_addr_first", rd_q[0], 5);
    check("t6_nwords", wd_q.size(), 1);
    if (wd_q.size() == 1) begin
      check("t6_data", wd_q[0], 32'hF);
      check("t6_nbits", wn_q[0], 4);
      check("t6_last", wl_q[0], 1);
    end
    repeat (3) @(negedge clk);
    check("t6_idle_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
